// File: rtl/brent_kung_subtractor16bit_if.sv
// Operand/result handshake bundle for the two-stage 16-bit subtractor.
// The master drives operands and accepts results; the slave is the subtractor.
interface brent_kung_subtractor16bit_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] minuend;
  logic [15:0] subtrahend;
  logic        borrowIn;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] difference;
  logic        borrowOut;
  logic        overflow;
  logic        zero;

  modport master (
    output in_valid, minuend, subtrahend, borrowIn, out_ready,
    input  in_ready, out_valid, difference, borrowOut, overflow, zero
  );

  modport slave (
    input  in_valid, minuend, subtrahend, borrowIn, out_ready,
    output in_ready, out_valid, difference, borrowOut, overflow, zero
  );
endinterface

// File: rtl/brent_kung_subtractor16bit.sv
// Two-stage pipelined 16-bit subtractor: A - B - borrowIn computed as A + ~B + !borrowIn,
// low byte in stage 1 and high byte in stage 2, each through an 8-bit Brent-Kung carry tree.
module brent_kung_subtractor16bit (
  input  logic                           clk,
  input  logic                           rst_n,
  brent_kung_subtractor16bit_if.slave    bus
);

  // Returns {carry_out, sum[7:0]} of a + b + cin using a Brent-Kung prefix tree.
  function automatic logic [8:0] bk_add8(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin);
    logic [7:0] p;
    logic [7:0] gg;
    logic [7:0] pg;
    logic [7:0] c;
    // NOTE: blocking assignments here on purpose -- each tree level reads the
    // group terms the previous level just produced, so evaluation order matters.
    p  = a ^ b;
    gg = a & b;
    pg = p;
    gg[0] = gg[0] | (p[0] & cin);
    for (int i = 1; i < 8; i += 2) begin
      gg[i] = gg[i] | (pg[i] & gg[i-1]);
      pg[i] = pg[i] & pg[i-1];
    end
    for (int i = 3; i < 8; i += 4) begin
      gg[i] = gg[i] | (pg[i] & gg[i-2]);
      pg[i] = pg[i] & pg[i-2];
    end
    gg[7] = gg[7] | (pg[7] & gg[3]);
    // Down-sweep fills in the carries the up-sweep skipped.
    gg[5] = gg[5] | (pg[5] & gg[3]);
    for (int i = 2; i < 8; i += 2) begin
      gg[i] = gg[i] | (pg[i] & gg[i-1]);
    end
    c = {gg[6:0], cin};
    return {gg[7], p ^ c};
  endfunction

  logic        s1_valid;
  logic [7:0]  s1_dlo;
  logic        s1_c8;
  logic [7:0]  s1_ahi;
  logic [7:0]  s1_nbhi;
  logic        s1_asign;
  logic        s1_bsign;

  logic        out_valid_q;
  logic [15:0] difference_q;
  logic        borrow_out_q;
  logic        overflow_q;
  logic        zero_q;

  logic        in_ready;
  logic        s1_load;
  logic        s2_load;
  logic [8:0]  lo_sum;
  logic [8:0]  hi_sum;
  logic        ovf_next;

  assign s2_load  = s1_valid && (!out_valid_q || bus.out_ready);
  assign in_ready = rst_n && (!s1_valid || s2_load);
  assign s1_load  = bus.in_valid && in_ready;

  // Carry into bit 0 is the complement of the incoming borrow.
  assign lo_sum   = bk_add8(bus.minuend[7:0], ~bus.subtrahend[7:0], ~bus.borrowIn);
  assign hi_sum   = bk_add8(s1_ahi, s1_nbhi, s1_c8);
  assign ovf_next = (s1_asign != s1_bsign) && (hi_sum[7] != s1_asign);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all state so every register samples pre-edge values
    // and the two stages shift together on one edge.
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_dlo       <= '0;
      s1_c8        <= 1'b0;
      s1_ahi       <= '0;
      s1_nbhi      <= '0;
      s1_asign     <= 1'b0;
      s1_bsign     <= 1'b0;
      out_valid_q  <= 1'b0;
      difference_q <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_dlo   <= lo_sum[7:0];
        s1_c8    <= lo_sum[8];
        s1_ahi   <= bus.minuend[15:8];
        s1_nbhi  <= ~bus.subtrahend[15:8];
        s1_asign <= bus.minuend[15];
        s1_bsign <= bus.subtrahend[15];
      end
      if (s1_load) begin
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      // Result registers only move on a stage-2 load, so they hold while stalled.
      if (s2_load) begin
        difference_q <= {hi_sum[7:0], s1_dlo};
        borrow_out_q <= ~hi_sum[8];
        overflow_q   <= ovf_next;
        zero_q       <= (hi_sum[7:0] == 8'h00) && (s1_dlo == 8'h00);
        out_valid_q  <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.difference = difference_q;
  assign bus.borrowOut  = borrow_out_q;
  assign bus.overflow   = overflow_q;
  assign bus.zero       = zero_q;

endmodule
